// File: rtl/ddr_app_arbiter.sv
// Shares the MIG 7-series app_* interface between a write requester and a read requester,
// one 256-bit beat per command, with read-outstanding limiting and write anti-starvation.
module ddr_app_arbiter #(
   parameter int ADDR_W     = 28,
   parameter int DATA_W     = 256,
   parameter int MASK_W     = 32,
   parameter int MAX_RD_OUT = 8,
   parameter int WR_STARVE  = 16
) (
   input  logic              ui_clk,
   input  logic              rst_n,
   input  logic              init_calib_complete,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [MASK_W-1:0] wr_mask,
   output logic              wr_ack,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_ack,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic [ADDR_W-1:0] app_addr,
   output logic [2:0]        app_cmd,
   output logic              app_en,
   input  logic              app_rdy,
   output logic [DATA_W-1:0] app_wdf_data,
   output logic [MASK_W-1:0] app_wdf_mask,
   output logic              app_wdf_wren,
   output logic              app_wdf_end,
   input  logic              app_wdf_rdy,
   input  logic [DATA_W-1:0] app_rd_data,
   input  logic              app_rd_data_valid
);

   localparam int CNT_W = $clog2(MAX_RD_OUT + 1);
   localparam int STV_W = $clog2(WR_STARVE + 1);
   localparam logic [CNT_W-1:0] RD_MAX  = CNT_W'(MAX_RD_OUT);
   localparam logic [CNT_W-1:0] RD_ONE  = CNT_W'(1);
   localparam logic [STV_W-1:0] STV_MAX = STV_W'(WR_STARVE);
   localparam logic [STV_W-1:0] STV_ONE = STV_W'(1);
   localparam logic [2:0]       CMD_WR  = 3'b000;
   localparam logic [2:0]       CMD_RD  = 3'b001;

   typedef enum logic [1:0] {
      IDLE,
      WR,
      RD
   } state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  rd_out, rd_out_nxt;
   logic [STV_W-1:0]  starve, starve_nxt;
   logic              grant_wr, grant_rd;
   logic              rd_accept, rd_return;

   logic              en_nxt, wren_nxt, wr_ack_nxt, rd_ack_nxt;
   logic [2:0]        cmd_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   logic [DATA_W-1:0] wdata_nxt;
   logic [MASK_W-1:0] wmask_nxt;

   function automatic logic [STV_W-1:0] starve_sat_inc(input logic [STV_W-1:0] cnt);
      return (cnt >= STV_MAX) ? STV_MAX : cnt + STV_ONE;
   endfunction

   // Grant decision: a starved write beats reads, reads beat ordinary writes.
   always_comb begin
      grant_wr = 1'b0;
      grant_rd = 1'b0;
      if (state == IDLE && init_calib_complete) begin
         if (wr_req && starve == STV_MAX)
            grant_wr = 1'b1;
         else if (rd_req && rd_out < RD_MAX)
            grant_rd = 1'b1;
         else if (wr_req)
            grant_wr = 1'b1;
      end
   end

   always_ff @(posedge ui_clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      en_nxt     = app_en;
      cmd_nxt    = app_cmd;
      addr_nxt   = app_addr;
      wdata_nxt  = app_wdf_data;
      wmask_nxt  = app_wdf_mask;
      wren_nxt   = app_wdf_wren;
      wr_ack_nxt = 1'b0;
      rd_ack_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (grant_wr) begin
               state_nxt  = WR;
               en_nxt     = 1'b1;
               cmd_nxt    = CMD_WR;
               addr_nxt   = wr_addr;
               wdata_nxt  = wr_data;
               wmask_nxt  = wr_mask;
               wren_nxt   = 1'b1;
               wr_ack_nxt = 1'b1;
            end else if (grant_rd) begin
               state_nxt  = RD;
               en_nxt     = 1'b1;
               cmd_nxt    = CMD_RD;
               addr_nxt   = rd_addr;
               rd_ack_nxt = 1'b1;
            end
         end
         WR: begin
            // Command and write-data handshakes retire independently.
            if (app_en && app_rdy)
               en_nxt = 1'b0;
            if (app_wdf_wren && app_wdf_rdy)
               wren_nxt = 1'b0;
            if (!en_nxt && !wren_nxt)
               state_nxt = IDLE;
         end
         RD: begin
            if (app_rdy) begin
               en_nxt    = 1'b0;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      rd_accept  = (state == RD) && app_en && app_rdy;
      rd_return  = app_rd_data_valid && (rd_out != '0);
      rd_out_nxt = rd_out;
      if (rd_accept && !rd_return)
         rd_out_nxt = rd_out + RD_ONE;
      else if (!rd_accept && rd_return)
         rd_out_nxt = rd_out - RD_ONE;

      starve_nxt = starve;
      if (!wr_req || grant_wr)
         starve_nxt = '0;
      else if (grant_rd)
         starve_nxt = starve_sat_inc(starve);
   end

   always_ff @(posedge ui_clk or negedge rst_n) begin
      if (!rst_n) begin
         app_en       <= 1'b0;
         app_cmd      <= '0;
         app_addr     <= '0;
         app_wdf_data <= '0;
         app_wdf_mask <= '0;
         app_wdf_wren <= 1'b0;
         wr_ack       <= 1'b0;
         rd_ack       <= 1'b0;
         rd_out       <= '0;
         starve       <= '0;
      end else begin
         app_en       <= en_nxt;
         app_cmd      <= cmd_nxt;
         app_addr     <= addr_nxt;
         app_wdf_data <= wdata_nxt;
         app_wdf_mask <= wmask_nxt;
         app_wdf_wren <= wren_nxt;
         wr_ack       <= wr_ack_nxt;
         rd_ack       <= rd_ack_nxt;
         rd_out       <= rd_out_nxt;
         starve       <= starve_nxt;
      end
   end

   // Single-beat bursts: every write-data beat is also the last one.
   assign app_wdf_end = app_wdf_wren;

   // Read return stage: one register, no back-pressure toward the MIG.
   always_ff @(posedge ui_clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_valid <= app_rd_data_valid;
         if (app_rd_data_valid)
            rd_data <= app_rd_data;
      end
   end

endmodule
